// File: rtl/elevator_pkg.sv
// Shared constants and helpers for the elevator controller and its front end.
// Channel layout used by call_request_latch: [2:0] hall up, [5:3] hall down, [9:6] cabin.
package elevator_pkg;

  localparam int NUM_FLOORS = 4;
  localparam int NUM_CH     = 3 * NUM_FLOORS - 2;
  localparam int UP_BASE    = 0;
  localparam int DOWN_BASE  = NUM_FLOORS - 1;
  localparam int IN_BASE    = 2 * (NUM_FLOORS - 1);

  localparam logic [2:0] POS_MAX = 3'd6;

  typedef enum logic [1:0] {
    DIR_STOP = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10,
    DIR_BAD  = 2'b11
  } dir_e;

  // Zero-based floor index of an even (at-floor) position code.
  function automatic logic [1:0] floor_of(input logic [2:0] position);
    return position[2:1];
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus saturating debounce counter for one push-button.
// accept is high for exactly one cycle: the DEBOUNCE_CYCLES-th consecutive synchronized high.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic accept
);

  localparam logic [3:0] CNT_LIMIT = 4'(DEBOUNCE_CYCLES);
  localparam logic [3:0] CNT_LAST  = 4'(DEBOUNCE_CYCLES - 1);

  logic [1:0] sync_q;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Counter saturates at the limit so a held button never fires twice.
  always_comb begin
    cnt_d = cnt_q;
    if (!sync_q[1]) begin
      cnt_d = 4'd0;
    end else if (cnt_q < CNT_LIMIT) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Synchronizer and counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
      cnt_q  <= 4'd0;
    end else begin
      sync_q <= {sync_q[0], raw};
      cnt_q  <= cnt_d;
    end
  end

  assign accept = sync_q[1] && (cnt_q == CNT_LAST);

endmodule

// File: rtl/call_request_latch.sv
// Debounced hall/cabin call latch feeding the elevator controller.
// Holds each accepted call until the controller reports serving it at that floor.
module call_request_latch
  import elevator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] raw_up,
  input  logic [2:0] raw_down,
  input  logic [3:0] raw_in,
  input  logic [2:0] position,
  input  logic       open,
  input  logic [1:0] direction,
  output logic [2:0] button_up,
  output logic [2:0] button_down,
  output logic [3:0] button_in,
  output logic       call_accepted
);

  logic [NUM_CH-1:0] raw_s;
  logic [NUM_CH-1:0] accept_s;
  logic [NUM_CH-1:0] service_s;
  logic [NUM_CH-1:0] pending_q;
  logic [NUM_CH-1:0] pending_d;
  logic              accepted_q;
  logic              accepted_d;
  logic              at_floor_s;
  logic [1:0]        floor_s;

  assign raw_s = {raw_in, raw_down, raw_up};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_s[g]),
      .accept(accept_s[g])
    );
  end

  // Service decode: door open at a valid floor with a legal direction.
  always_comb begin
    service_s  = '0;
    floor_s    = floor_of(position);
    at_floor_s = open && !position[0] && (position <= POS_MAX) && (direction != DIR_BAD);
    for (int i = 0; i < NUM_FLOORS; i++) begin
      service_s[IN_BASE + i] = at_floor_s && (floor_s == 2'(i));
    end
    for (int i = 0; i < NUM_FLOORS - 1; i++) begin
      service_s[UP_BASE + i]   = at_floor_s && (floor_s == 2'(i))     && (direction != DIR_DOWN);
      service_s[DOWN_BASE + i] = at_floor_s && (floor_s == 2'(i + 1)) && (direction != DIR_UP);
    end
  end

  // A clear in the same cycle as an accept wins: that call is being served now.
  always_comb begin
    pending_d  = (pending_q | accept_s) & ~service_s;
    accepted_d = |(accept_s & ~service_s & ~pending_q);
  end

  // Pending requests and chime pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q  <= '0;
      accepted_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      accepted_q <= accepted_d;
    end
  end

  assign button_up     = pending_q[UP_BASE   +: NUM_FLOORS - 1];
  assign button_down   = pending_q[DOWN_BASE +: NUM_FLOORS - 1];
  assign button_in     = pending_q[IN_BASE   +: NUM_FLOORS];
  assign call_accepted = accepted_q;

endmodule
